// File: rtl/ysyx_25020037_icache.sv
// ysyx_25020037_icache
// Direct-mapped instruction cache between the IFU and the fetch memory path.
// A lookup is combinational: the indexed line's word comes out on icache_data
// and icache_hit qualifies it. A miss raises mem_req for one cycle and latches
// the block base address. The cache then waits in REFILL until the IFU returns
// the whole line with a one-cycle mem_ready pulse. fence_i invalidates every line.
//
// Ports
//   clk, rst       : single clock, synchronous active-high reset
//   icache_addr    : fetch PC
//   icache_req     : lookup active this cycle
//   icache_data    : selected instruction word (valid only when icache_hit)
//   icache_hit     : lookup hit
//   icache_ready   : cache idle and able to serve lookups
//   mem_req        : line refill request (one cycle, issued in IDLE)
//   mem_addr       : block base address of the refill
//   mem_data       : refill line, word i at bits [32i+31:32i]
//   mem_ready      : refill data valid pulse
//   fence_i        : invalidate all lines
//   hit_cnt        : lookup hit counter
//   miss_cnt       : refill request counter
module ysyx_25020037_icache #(
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_LINES  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             icache_addr,
    input  logic                    icache_req,
    output logic [31:0]             icache_data,
    output logic                    icache_hit,
    output logic                    icache_ready,
    output logic                    mem_req,
    output logic [31:0]             mem_addr,
    input  logic [BLOCK_SIZE*8-1:0] mem_data,
    input  logic                    mem_ready,
    input  logic                    fence_i,
    output logic [31:0]             hit_cnt,
    output logic [31:0]             miss_cnt
);
    localparam int OFF    = $clog2(BLOCK_SIZE);
    localparam int IDX    = $clog2(NUM_LINES);
    localparam int TAG_W  = 32 - OFF - IDX;
    localparam int WORDS  = BLOCK_SIZE / 4;
    localparam int WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic {IDLE, REFILL} state_t;

    state_t state, state_nxt;

    logic [NUM_LINES-1:0]   valid;
    logic [TAG_W-1:0]       tags  [NUM_LINES];
    logic [WORDS-1:0][31:0] lines [NUM_LINES];

    // Only the block base is kept for an outstanding refill; the line index
    // and tag are slices of it.
    logic [31:0]      rf_base;
    logic [IDX-1:0]   rf_idx;
    logic [TAG_W-1:0] rf_tag;
    logic             flush_pend;

    logic [IDX-1:0]    index;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] word_sel;
    logic [31:0]       base;
    logic              refill_done;
    logic              unused_addr_lsb;

    assign index  = icache_addr[OFF+IDX-1:OFF];
    assign tag    = icache_addr[31:OFF+IDX];
    assign base   = {icache_addr[31:OFF], {OFF{1'b0}}};
    assign rf_idx = rf_base[OFF+IDX-1:OFF];
    assign rf_tag = rf_base[31:OFF+IDX];
    assign unused_addr_lsb = &{1'b0, icache_addr[1:0]};

    // A one-word line has no word-select field in the address.
    generate
        if (WORDS > 1) begin : g_wsel
            assign word_sel = icache_addr[OFF-1:2];
        end else begin : g_wsel_one
            assign word_sel = 1'b0;
        end
    endgenerate

    assign icache_ready = (state == IDLE);
    assign icache_hit   = icache_ready & valid[index] & (tags[index] == tag) & ~fence_i;
    assign icache_data  = lines[index][word_sel];
    assign mem_req      = icache_ready & icache_req & ~icache_hit & ~fence_i;
    assign mem_addr     = icache_ready ? base : rf_base;
    assign refill_done  = (state == REFILL) & mem_ready;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mem_req)   state_nxt = REFILL;
            REFILL:  if (mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            valid      <= '0;
            flush_pend <= 1'b0;
            rf_base    <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (icache_req && icache_hit) hit_cnt  <= hit_cnt + 32'd1;
            if (mem_req)                  miss_cnt <= miss_cnt + 32'd1;
            if (mem_req)                  rf_base  <= base;
            if (state == IDLE) begin
                if (fence_i) valid <= '0;
            end else if (mem_ready) begin
                // A fence seen at any point during the refill, including
                // the completing cycle, wins over installing the line.
                flush_pend <= 1'b0;
                if (flush_pend || fence_i) valid <= '0;
                else                       valid[rf_idx] <= 1'b1;
            end else if (fence_i) begin
                flush_pend <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits guard them.
    // Reset forces IDLE, so a mem_ready arriving after it cannot write.
    always_ff @(posedge clk) begin
        if (refill_done && !rst) begin
            tags[rf_idx]  <= rf_tag;
            lines[rf_idx] <= mem_data;
        end
    end
endmodule

// File: tb/tb_ysyx_25020037_icache.sv
module tb_ysyx_25020037_icache;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  icache_addr;
    logic         icache_req;
    logic [31:0]  icache_data;
    logic         icache_hit;
    logic         icache_ready;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic [127:0] mem_data;
    logic         mem_ready;
    logic         fence_i;
    logic [31:0]  hit_cnt;
    logic [31:0]  miss_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_25020037_icache #(.BLOCK_SIZE(16), .NUM_LINES(16)) dut (
        .clk(clk), .rst(rst),
        .icache_addr(icache_addr), .icache_req(icache_req),
        .icache_data(icache_data), .icache_hit(icache_hit),
        .icache_ready(icache_ready), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_ready(mem_ready), .fence_i(fence_i),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a table of 16 one-block entries addressed by
    // (addr / 16) % 16, holding the tag addr / 256 and four words.
    bit          m_valid [16];
    logic [23:0] m_tag   [16];
    logic [31:0] m_word  [16][4];
    bit          m_refill;
    bit          m_pend;
    logic [31:0] m_base;
    logic [31:0] m_hits;
    logic [31:0] m_misses;

    bit          e_hit, e_mreq, e_ready;
    logic [31:0] e_maddr, e_data;

    task automatic model_eval();
        int li = int'((icache_addr / 16) % 16);
        int wi = int'((icache_addr / 4) % 4);
        e_ready = !m_refill;
        e_hit   = e_ready && m_valid[li] && (m_tag[li] == icache_addr[31:8]) && !fence_i;
        e_mreq  = e_ready && icache_req && !e_hit && !fence_i;
        e_maddr = m_refill ? m_base : (icache_addr / 16) * 16;
        e_data  = m_word[li][wi];
    endtask

    task automatic model_update();
        model_eval();
        if (rst) begin
            m_refill = 0; m_pend = 0; m_hits = 0; m_misses = 0;
            foreach (m_valid[i]) m_valid[i] = 0;
        end else if (!m_refill) begin
            if (fence_i) foreach (m_valid[i]) m_valid[i] = 0;
            if (icache_req && e_hit) m_hits = m_hits + 1;
            if (e_mreq) begin
                m_misses = m_misses + 1;
                m_refill = 1;
                m_base   = e_maddr;
            end
        end else if (mem_ready) begin
            int li = int'((m_base / 16) % 16);
            for (int w = 0; w < 4; w++) m_word[li][w] = mem_data[32*w +: 32];
            if (m_pend || fence_i) foreach (m_valid[i]) m_valid[i] = 0;
            else begin
                m_valid[li] = 1;
                m_tag[li]   = m_base[31:8];
            end
            m_refill = 0;
            m_pend   = 0;
        end else if (fence_i) begin
            m_pend = 1;
        end
    endtask

    // Advance one clock; inputs change 1ns after the edge.
    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic refill(input logic [31:0] a);
        icache_addr = a; icache_req = 1; fence_i = 0;
        tick();
        mem_ready = 1;
        mem_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        mem_ready = 0; icache_req = 0;
    endtask

    task automatic test_reset();
        rst = 1; icache_addr = 0; icache_req = 0; mem_data = '0;
        mem_ready = 0; fence_i = 0; m_base = 0;
        tick(); tick();
        rst = 0; #1;
        n_tests++; if (icache_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", icache_ready); end
        n_tests++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", icache_hit); end
        n_tests++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
        n_tests++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    endtask

    task automatic test_cold_miss();
        icache_addr = 32'h3000_0000; icache_req = 1; #1;
        n_tests++; if (icache_hit !== 1'b0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL cold_lookup hit=%b mem_req=%b want 0/1", icache_hit, mem_req); end
        n_tests++; if (mem_addr !== 32'h3000_0000) begin n_fail++; $display("FAIL cold_mem_addr got %h want 30000000", mem_addr); end
        tick();
        n_tests++; if (icache_ready !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL cold_refill ready=%b mem_req=%b want 0/0", icache_ready, mem_req); end
        mem_ready = 1; mem_data = {32'd4, 32'd3, 32'd2, 32'd1};
        tick();
        mem_ready = 0; #1;
        n_tests++; if (icache_hit !== 1'b1 || icache_data !== 32'd1) begin n_fail++; $display("FAIL cold_after hit=%b data=%h want 1/00000001", icache_hit, icache_data); end
        n_tests++; if (miss_cnt !== 32'd1) begin n_fail++; $display("FAIL cold_miss_cnt got %0d want 1", miss_cnt); end
    endtask

    task automatic test_word_select();
        icache_addr = 32'h3000_000C; icache_req = 1; #1;
        n_tests++; if (icache_hit !== 1'b1 || icache_data !== 32'd4) begin n_fail++; $display("FAIL word_sel hit=%b data=%h want 1/00000004", icache_hit, icache_data); end
        icache_addr = 32'h3000_0008; #1;
        n_tests++; if (icache_data !== 32'd3) begin n_fail++; $display("FAIL word_sel2 data=%h want 00000003", icache_data); end
        tick(); tick(); tick();
        n_tests++; if (hit_cnt !== 32'd3) begin n_fail++; $display("FAIL word_hit_cnt got %0d want 3", hit_cnt); end
    endtask

    task automatic test_conflict();
        icache_addr = 32'h3000_0100; icache_req = 1; #1;
        n_tests++; if (icache_hit !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h3000_0100) begin n_fail++; $display("FAIL conflict_miss hit=%b req=%b addr=%h", icache_hit, mem_req, mem_addr); end
        tick();
        mem_ready = 1; mem_data = {4{32'hAAAA_AAAA}};
        tick();
        mem_ready = 0; #1;
        n_tests++; if (icache_hit !== 1'b1 || icache_data !== 32'hAAAA_AAAA) begin n_fail++; $display("FAIL conflict_fill hit=%b data=%h want 1/aaaaaaaa", icache_hit, icache_data); end
        icache_addr = 32'h3000_0000; #1;
        n_tests++; if (icache_hit !== 1'b0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL conflict_evict hit=%b mem_req=%b want 0/1", icache_hit, mem_req); end
        tick();
        mem_ready = 1; mem_data = {32'd8, 32'd7, 32'd6, 32'd5};
        tick();
        mem_ready = 0; #1;
        n_tests++; if (icache_hit !== 1'b1 || icache_data !== 32'd5) begin n_fail++; $display("FAIL conflict_refill hit=%b data=%h want 1/00000005", icache_hit, icache_data); end
        n_tests++; if (miss_cnt !== 32'd3) begin n_fail++; $display("FAIL conflict_miss_cnt got %0d want 3", miss_cnt); end
        icache_req = 0;
    endtask

    task automatic test_fence_idle();
        logic [31:0] addrs [3];
        addrs[0] = 32'h3000_0000; addrs[1] = 32'h3000_0010; addrs[2] = 32'h8000_1234;
        refill(addrs[1]);
        refill(addrs[2]);
        foreach (addrs[i]) begin
            icache_addr = addrs[i]; #1;
            n_tests++; if (icache_hit !== 1'b1) begin n_fail++; $display("FAIL fence_pre_hit addr=%h got %b want 1", addrs[i], icache_hit); end
        end
        icache_addr = addrs[0]; icache_req = 1; fence_i = 1; #1;
        n_tests++; if (icache_hit !== 1'b0 || mem_req !== 1'b0) begin n_fail++; $display("FAIL fence_same_cycle hit=%b mem_req=%b want 0/0", icache_hit, mem_req); end
        tick();
        fence_i = 0; icache_req = 0;
        foreach (addrs[i]) begin
            icache_addr = addrs[i]; #1;
            n_tests++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL fence_post_hit addr=%h got %b want 0", addrs[i], icache_hit); end
        end
        n_tests++; if (icache_ready !== 1'b1 || miss_cnt !== 32'd5) begin n_fail++; $display("FAIL fence_state ready=%b miss_cnt=%0d want 1/5", icache_ready, miss_cnt); end
    endtask

    task automatic test_fence_refill();
        icache_addr = 32'h4000_0020; icache_req = 1;
        tick();
        fence_i = 1;
        tick();
        fence_i = 0;
        tick();
        n_tests++; if (icache_ready !== 1'b0) begin n_fail++; $display("FAIL fence_refill_wait ready=%b want 0", icache_ready); end
        mem_ready = 1; mem_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        mem_ready = 0; #1;
        n_tests++; if (icache_ready !== 1'b1 || icache_hit !== 1'b0 || mem_req !== 1'b1) begin n_fail++; $display("FAIL fence_refill_done ready=%b hit=%b mem_req=%b want 1/0/1", icache_ready, icache_hit, mem_req); end
        icache_req = 0;
    endtask

    task automatic test_reset_refill();
        refill(32'h3000_0000);
        icache_addr = 32'h5000_0000; icache_req = 1;
        tick();
        icache_req = 0; rst = 1;
        tick();
        rst = 0; mem_ready = 1; mem_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        tick();
        mem_ready = 0; #1;
        n_tests++; if (icache_ready !== 1'b1 || mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_refill_state ready=%b mem_req=%b want 1/0", icache_ready, mem_req); end
        n_tests++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_refill_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
        n_tests++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL rst_refill_hit1 got %b want 0", icache_hit); end
        icache_addr = 32'h3000_0000; #1;
        n_tests++; if (icache_hit !== 1'b0) begin n_fail++; $display("FAIL rst_refill_hit2 got %b want 0", icache_hit); end
    endtask

    task automatic test_random();
        logic [23:0] tg;
        logic [3:0]  ix;
        logic [1:0]  wd;
        int          bad = 0;
        for (int c = 0; c < 600; c++) begin
            case ($urandom_range(0, 2))
                0:       tg = 24'h30_0000;
                1:       tg = 24'h30_0001;
                default: tg = 24'h80_0000;
            endcase
            ix = 4'($urandom_range(0, 3));
            wd = 2'($urandom_range(0, 3));
            icache_addr = {tg, ix, wd, 2'b00};
            icache_req  = ($urandom_range(0, 3) != 0);
            fence_i     = ($urandom_range(0, 24) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            mem_ready   = m_refill ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            mem_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
            #1;
            model_eval();
            n_tests++;
            if (icache_ready !== e_ready || icache_hit !== e_hit || mem_req !== e_mreq || mem_addr !== e_maddr
                || (e_hit && icache_data !== e_data)) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand_comb cyc=%0d ready=%b/%b hit=%b/%b mem_req=%b/%b mem_addr=%h/%h data=%h/%h",
                    c, icache_ready, e_ready, icache_hit, e_hit, mem_req, e_mreq, mem_addr, e_maddr, icache_data, e_data);
            end
            tick();
            n_tests++;
            if (hit_cnt !== m_hits || miss_cnt !== m_misses) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand_cnt cyc=%0d hit_cnt=%0d/%0d miss_cnt=%0d/%0d", c, hit_cnt, m_hits, miss_cnt, m_misses);
            end
        end
        rst = 0; mem_ready = 0; fence_i = 0; icache_req = 0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_word_select();
        test_conflict();
        test_fence_idle();
        test_fence_refill();
        test_reset_refill();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_25020037_icache.md
YSYX_25020037_ICACHE -- requirements
Module: ysyx_25020037_icache

Interface
REQ-001 SHALL have parameter BLOCK_SIZE, default 16, meaning line size in bytes (power of two, >=4).
REQ-002 SHALL have parameter NUM_LINES, default 16, meaning number of direct-mapped lines (power of two, >=2).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-005 SHALL have port icache_addr  in  32  fetch PC from IFU.
REQ-006 SHALL have port icache_req  in  1  IFU lookup active this cycle (IFU ties to idu_ready).
REQ-007 SHALL have port icache_data  out  32  instruction word selected by icache_addr.
REQ-008 SHALL have port icache_hit  out  1  lookup hit.
REQ-009 SHALL have port icache_ready  out  1  cache in IDLE, able to serve lookups.
REQ-010 SHALL have port mem_req  out  1  line refill request to IFU.
REQ-011 SHALL have port mem_addr  out  32  block base address of refill.
REQ-012 SHALL have port mem_data  in  BLOCK_SIZE*8  refill line; word i at bits [32i+31:32i].
REQ-013 SHALL have port mem_ready  in  1  one-cycle pulse: mem_data valid.
REQ-014 SHALL have port fence_i  in  1  invalidate all lines.
REQ-015 SHALL have ports hit_cnt, miss_cnt  out  32 each  performance counters.

Function
REQ-016 SHALL split addresses as OFF=log2(BLOCK_SIZE), IDX=log2(NUM_LINES): word = addr[OFF-1:2], index = addr[OFF+IDX-1:OFF], tag = addr[31:OFF+IDX].
REQ-017 SHALL store per line: valid bit, tag, and BLOCK_SIZE*8 data bits.
REQ-018 SHALL implement states IDLE and REFILL; icache_ready = (state==IDLE).
REQ-019 SHALL drive icache_hit combinationally = IDLE & valid[index] & tag match & !fence_i.
REQ-020 SHALL drive icache_data combinationally from the indexed line's selected word, independent of hit.
REQ-021 SHALL drive mem_req combinationally = IDLE & icache_req & !icache_hit & !fence_i.
REQ-022 SHALL drive mem_addr = {icache_addr[31:OFF], OFF zeros} in IDLE, and the latched base in REFILL.
REQ-023 SHALL, on mem_req, latch index/tag/base and enter REFILL next cycle.
REQ-024 SHALL stay in REFILL until mem_ready; mem_req held 0 while in REFILL.
REQ-025 SHALL, on mem_ready in REFILL, write mem_data, latched tag, valid=1 into latched line and return to IDLE; following cycle a lookup of that address hits (latency: hit data one cycle after mem_ready).
REQ-026 SHALL ignore mem_ready in IDLE.
REQ-027 SHALL, on fence_i in IDLE, clear all valid bits at that edge; no refill starts that cycle.
REQ-028 SHALL, on fence_i in REFILL, set a pending-flush flag; on mem_ready the line is not marked valid, all valid bits cleared, flag cleared, state IDLE.
REQ-029 SHALL increment hit_cnt each IDLE cycle with icache_req & icache_hit, miss_cnt each cycle mem_req=1; both wrap modulo 2^32.
REQ-030 SHALL replace a conflicting line (same index, different tag) on refill with no write-back.

Reset
REQ-031 SHALL on rst: state IDLE, all valid 0, pending flush 0, hit_cnt=miss_cnt=0; outputs icache_hit=0, mem_req=0 (given icache_req=0 or next cycle), icache_ready=1.
REQ-032 SHALL, on rst during REFILL, abandon the refill; a later mem_ready is ignored.
REQ-033 SHALL leave data array contents unspecified after reset (not required to clear).

Verification (BLOCK_SIZE=16, NUM_LINES=16)
REQ-034 Cold miss: reset, addr=0x30000000, req=1 -> hit=0, mem_req=1, mem_addr=0x30000000; next cycle ready=0; mem_ready with words {w3..w0}={4,3,2,1} -> next cycle hit=1, data=1, miss_cnt=1.
REQ-035 Word select: after 034, addr=0x3000000C, req=1 -> hit=1, data=4, hit_cnt increments by 1 per cycle.
REQ-036 Conflict: after 034, addr=0x30000100 -> miss, refill with 0xAA.. ; then addr=0x30000000 -> hit=0, mem_req=1.
REQ-037 fence_i in IDLE after fills -> next cycle every prior address hit=0.
REQ-038 fence_i pulse mid-REFILL, then mem_ready -> IDLE, refilled address still hit=0.
REQ-039 rst asserted mid-REFILL, then mem_ready -> ignored, ready=1, all lookups miss, counters 0.
